// File: rtl/router_pkg.sv
// router_pkg: shared types, header field layout and destination constants for the 1x3 router controller
package router_pkg;
  localparam int DATA_W = 8;
  localparam int NUM_DEST = 3;
  localparam int LEN_W = 6;
  localparam logic [1:0] ADDR_INVALID = 2'b11;
  localparam int HDR_ADDR_LSB = 0;
  localparam int HDR_ADDR_MSB = 1;
  localparam int HDR_LEN_LSB = 2;
  localparam int HDR_LEN_MSB = 7;
  typedef enum logic [2:0] {IDLE, WAIT_EMPTY, LOAD, CHECK, DROP} ctrl_state_e;
  function automatic logic [NUM_DEST-1:0] dest_onehot(input logic [1:0] a);
    return NUM_DEST'(1) << a;
  endfunction
endpackage

// File: rtl/router_if.sv
// router_if: source byte stream (pkt_valid/din/busy), FIFO status (full/empty/soft_rst) and FIFO write side (wr_en/wr_data/dest/error)
interface router_if;
  import router_pkg::*;
  logic                pkt_valid;
  logic [DATA_W-1:0]   din;
  logic [NUM_DEST-1:0] fifo_full;
  logic [NUM_DEST-1:0] fifo_empty;
  logic [NUM_DEST-1:0] soft_rst;
  logic                busy;
  logic                error;
  logic [NUM_DEST-1:0] wr_en;
  logic [DATA_W-1:0]   wr_data;
  logic [1:0]          dest;
  modport master (
    output pkt_valid, din, fifo_full, fifo_empty, soft_rst,
    input  busy, error, wr_en, wr_data, dest
  );
  modport slave (
    input  pkt_valid, din, fifo_full, fifo_empty, soft_rst,
    output busy, error, wr_en, wr_data, dest
  );
endinterface

// File: rtl/router_pkt_counter.sv
// router_pkt_counter: payload down-counter and running XOR parity; in clk/rst/i_clr/i_load/i_len/i_seed/i_step/i_data, out o_last/o_parity
module router_pkt_counter
  import router_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_load,
  input  logic [LEN_W-1:0]  i_len,
  input  logic [DATA_W-1:0] i_seed,
  input  logic              i_step,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_last,
  output logic [DATA_W-1:0] o_parity
);
  logic [LEN_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_par;
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
      r_par <= '0;
    end else if (i_load) begin
      r_cnt <= i_len;
      r_par <= i_seed;
    end else if (i_step) begin
      r_cnt <= r_cnt - 1'b1;
      r_par <= r_par ^ i_data;
    end
  end
  assign o_last   = (r_cnt == '0);
  assign o_parity = r_par;
endmodule

// File: rtl/router_ctrl.sv
// router_ctrl: packet sequencer; in clk/rst + router_if.slave bus (byte stream, FIFO status), out busy/error/wr_en/wr_data/dest
module router_ctrl
  import router_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  router_if.slave  bus
);
  ctrl_state_e         r_state, w_next;
  logic [NUM_DEST-1:0] r_wr_en;
  logic [DATA_W-1:0]   r_wr_data, r_hdr, r_rcvd, w_calc, w_new_data;
  logic                r_error, w_busy, w_acc, w_hold, w_hdr_ok, w_srst, w_last, w_new_wr, w_step, w_load;
  logic [1:0]          r_dest, w_addr, w_new_dest;
  logic [LEN_W-1:0]    w_len;
  assign w_addr   = bus.din[HDR_ADDR_MSB:HDR_ADDR_LSB];
  assign w_len    = bus.din[HDR_LEN_MSB:HDR_LEN_LSB];
  assign w_hdr_ok = (w_addr != ADDR_INVALID) && (w_len != '0);
  assign w_hold   = (r_wr_en != '0) && bus.fifo_full[r_dest];
  assign w_acc    = bus.pkt_valid && !w_busy;
  assign w_srst   = bus.soft_rst[r_dest] && (r_state inside {WAIT_EMPTY, LOAD, CHECK});
  assign w_load   = (r_state == IDLE) && w_acc;
  // the parity byte itself is not folded into the running XOR; it is kept in r_rcvd for the compare
  assign w_step   = (r_state inside {LOAD, DROP}) && w_acc && !w_last;
  router_pkt_counter u_cnt (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_srst),
    .i_load   (w_load),
    .i_len    (w_len),
    .i_seed   (bus.din),
    .i_step   (w_step),
    .i_data   (bus.din),
    .o_last   (w_last),
    .o_parity (w_calc)
  );
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:       if (w_acc) w_next = !w_hdr_ok ? DROP : bus.fifo_empty[w_addr] ? LOAD : WAIT_EMPTY;
      WAIT_EMPTY: if (bus.fifo_empty[r_dest]) w_next = LOAD;
      LOAD:       if (w_acc && w_last) w_next = CHECK;
      CHECK:      if (!w_hold) w_next = IDLE;
      DROP:       if (w_acc && w_last) w_next = IDLE;
      default:    w_next = IDLE;
    endcase
    if (w_srst) w_next = IDLE;
  end
  always_comb begin
    w_busy     = (r_state inside {WAIT_EMPTY, CHECK}) || w_hold;
    w_new_wr   = (w_load && w_hdr_ok && bus.fifo_empty[w_addr]) ||
                 (r_state == WAIT_EMPTY && bus.fifo_empty[r_dest]) ||
                 (r_state == LOAD && w_acc);
    w_new_dest = (r_state == IDLE) ? w_addr : r_dest;
    w_new_data = (r_state == WAIT_EMPTY) ? r_hdr : bus.din;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_en   <= '0;
      r_wr_data <= '0;
      r_error   <= 1'b0;
      r_dest    <= '0;
      r_hdr     <= '0;
      r_rcvd    <= '0;
    end else begin
      if (w_srst) r_wr_en <= '0;
      else if (!w_hold) begin
        r_wr_en <= w_new_wr ? dest_onehot(w_new_dest) : '0;
        if (w_new_wr) r_wr_data <= w_new_data;
      end
      if (w_load) begin
        r_error <= !w_hdr_ok;
        if (w_hdr_ok) begin
          r_dest <= w_addr;
          r_hdr  <= bus.din;
        end
      end
      if (r_state == LOAD && w_acc && w_last) r_rcvd <= bus.din;
      if (r_state == CHECK && !w_hold && !w_srst) r_error <= (w_calc != r_rcvd);
    end
  end
  assign bus.busy    = w_busy;
  assign bus.error   = r_error;
  assign bus.wr_en   = r_wr_en;
  assign bus.wr_data = r_wr_data;
  assign bus.dest    = r_dest;
endmodule

// File: tb/tb_router_ctrl.sv
// tb_router_ctrl: table-driven per-cycle vectors plus a hand-written bad-parity sequence for router_ctrl
module tb_router_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  router_if bus();
  router_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic       rst, pv;
    logic [7:0] din;
    logic [2:0] full, empty, srst;
    logic [2:0] e_wr;
    logic [7:0] e_data;
    logic       e_err, e_busy;
    logic [1:0] e_dest;
  } vec_t;
  vec_t vecs[$];
  task automatic add(input logic r, input logic pv, input logic [7:0] din, input logic [2:0] full,
                     input logic [2:0] empty, input logic [2:0] srst, input logic [2:0] e_wr,
                     input logic [7:0] e_data, input logic e_err, input logic e_busy, input logic [1:0] e_dest);
    vec_t v;
    v.rst = r; v.pv = pv; v.din = din; v.full = full; v.empty = empty; v.srst = srst;
    v.e_wr = e_wr; v.e_data = e_data; v.e_err = e_err; v.e_busy = e_busy; v.e_dest = e_dest;
    vecs.push_back(v);
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    bus.pkt_valid = 1'b1;
    bus.din = b;
    #1;
    while (bus.busy && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("send_busy_timeout", 32'(n >= 20), 32'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    bus.pkt_valid = 1'b0; bus.din = '0; bus.fifo_full = '0; bus.fifo_empty = 3'b111; bus.soft_rst = '0;
    add(0,1,8'h0D,0,7,0, 0,8'h00,0,0,0);
    add(0,1,8'h11,0,7,0, 2,8'h0D,0,0,1);
    add(0,1,8'h22,0,7,0, 2,8'h11,0,0,1);
    add(0,1,8'h33,0,7,0, 2,8'h22,0,0,1);
    add(0,1,8'h0D,0,7,0, 2,8'h33,0,0,1);
    add(0,0,8'h00,0,7,0, 2,8'h0D,0,1,1);
    add(0,1,8'h0D,0,7,0, 0,8'h0D,0,0,1);
    add(0,1,8'h11,0,7,0, 2,8'h0D,0,0,1);
    add(0,1,8'h22,0,7,0, 2,8'h11,0,0,1);
    add(0,1,8'h33,0,7,0, 2,8'h22,0,0,1);
    add(0,1,8'h00,0,7,0, 2,8'h33,0,0,1);
    add(0,0,8'h00,0,7,0, 2,8'h00,0,1,1);
    add(0,0,8'h00,0,7,0, 0,8'h00,1,0,1);
    add(0,1,8'h06,0,3,0, 0,8'h00,1,0,1);
    add(0,1,8'h44,0,3,0, 0,8'h00,0,1,2);
    add(0,1,8'h44,0,7,0, 0,8'h00,0,1,2);
    add(0,1,8'h44,0,7,0, 4,8'h06,0,0,2);
    add(0,1,8'h42,0,7,0, 4,8'h44,0,0,2);
    add(0,0,8'h00,0,7,0, 4,8'h42,0,1,2);
    add(0,1,8'h0C,0,7,0, 0,8'h42,0,0,2);
    add(0,1,8'hA1,0,7,0, 1,8'h0C,0,0,0);
    add(0,1,8'hB2,0,7,0, 1,8'hA1,0,0,0);
    add(0,1,8'hC3,1,7,0, 1,8'hB2,0,1,0);
    add(0,1,8'hC3,1,7,0, 1,8'hB2,0,1,0);
    add(0,1,8'hC3,0,7,0, 1,8'hB2,0,0,0);
    add(0,1,8'hDC,0,7,0, 1,8'hC3,0,0,0);
    add(0,0,8'h00,1,7,0, 1,8'hDC,0,1,0);
    add(0,0,8'h00,0,7,0, 1,8'hDC,0,1,0);
    add(0,1,8'h07,0,7,0, 0,8'hDC,0,0,0);
    add(0,1,8'h55,0,7,0, 0,8'hDC,1,0,0);
    add(0,1,8'h66,0,7,0, 0,8'hDC,1,0,0);
    add(0,1,8'h08,0,7,0, 0,8'hDC,1,0,0);
    add(0,1,8'h12,0,7,4, 1,8'h08,0,0,0);
    add(0,1,8'h34,0,7,1, 1,8'h12,0,0,0);
    add(0,0,8'h00,0,7,0, 0,8'h12,0,0,0);
    add(0,1,8'h05,0,7,0, 0,8'h12,0,0,0);
    add(0,1,8'h77,0,7,0, 2,8'h05,0,0,1);
    add(0,1,8'h72,0,7,0, 2,8'h77,0,0,1);
    add(0,0,8'h00,0,7,0, 2,8'h72,0,1,1);
    add(0,1,8'h0D,0,7,0, 0,8'h72,0,0,1);
    add(0,1,8'h11,0,7,0, 2,8'h0D,0,0,1);
    add(1,1,8'h22,0,7,0, 2,8'h11,0,0,1);
    add(0,0,8'h00,0,7,0, 0,8'h00,0,0,0);
    add(0,1,8'h01,0,7,0, 0,8'h00,0,0,0);
    add(0,1,8'h99,0,7,0, 0,8'h00,1,0,0);
    add(0,0,8'h00,0,7,0, 0,8'h00,1,0,0);
    repeat (2) @(negedge clk);
    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; bus.pkt_valid = vecs[i].pv; bus.din = vecs[i].din;
      bus.fifo_full = vecs[i].full; bus.fifo_empty = vecs[i].empty; bus.soft_rst = vecs[i].srst;
      #1;
      checks++;
      if ({bus.wr_en, bus.wr_data, bus.error, bus.busy, bus.dest} !==
          {vecs[i].e_wr, vecs[i].e_data, vecs[i].e_err, vecs[i].e_busy, vecs[i].e_dest}) begin
        errors++;
        $display("FAIL vec%0d got wr_en=%b data=%h err=%b busy=%b dest=%0d expected wr_en=%b data=%h err=%b busy=%b dest=%0d",
                 i, bus.wr_en, bus.wr_data, bus.error, bus.busy, bus.dest,
                 vecs[i].e_wr, vecs[i].e_data, vecs[i].e_err, vecs[i].e_busy, vecs[i].e_dest);
      end
    end
    rst = 1'b0; bus.fifo_full = '0; bus.fifo_empty = 3'b111; bus.soft_rst = '0;
    send(8'h09);
    send(8'h10);
    send(8'h20);
    send(8'hFF);
    @(negedge clk);
    bus.pkt_valid = 1'b0;
    #1;
    chk("check_busy", 32'(bus.busy), 32'd1);
    chk("check_err_cleared", 32'(bus.error), 32'd0);
    chk("parity_written", {21'd0, bus.wr_en, bus.wr_data}, {21'd0, 3'b010, 8'hFF});
    @(negedge clk);
    #1;
    chk("parity_err_set", 32'(bus.error), 32'd1);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_wr_en", 32'(bus.wr_en), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
